// File: rtl/qz4_sweep_if.sv
// qz4_sweep_if: stimulus/response and result bus between the qz4 sweep
// checker (master) and whatever consumes it (slave: the qz4 DUT loopback
// plus the host that starts sweeps and reads the results).
interface qz4_sweep_if;
  logic        start;
  logic [5:0]  stim;
  logic [3:0]  resp;
  logic        busy;
  logic        done;
  logic [6:0]  err_count;
  logic        first_fail_valid;
  logic [5:0]  first_fail_idx;
  logic [15:0] signature;

  modport master (
    input  start, resp,
    output stim, busy, done, err_count, first_fail_valid, first_fail_idx, signature
  );

  modport slave (
    output start, resp,
    input  stim, busy, done, err_count, first_fail_valid, first_fail_idx, signature
  );
endinterface

// File: rtl/qz4_sweep_checker.sv
// qz4_sweep_checker: sweeps all 64 {a,b,c,d,e,f} vectors into the qz4
// datapath, samples {W,X,Y,Z} after SETTLE_CYCLES, folds every response
// into a 16-bit MISR and, with QZ4_SWEEP_GOLDEN_EN defined, compares each
// response against a built-in golden model and records mismatches.
// Without QZ4_SWEEP_GOLDEN_EN the comparator is absent and the error
// outputs are tied to zero; sequencing and signature are unchanged.
module qz4_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  qz4_sweep_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle-counter value before moving to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  settle_cnt_r;
  logic [5:0]  stim_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] sig_r;
  logic        accept_s;

  // One MISR step: shift left, feed back the CCITT taps, xor in the response.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [3:0] r);
    misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {12'h000, r};
  endfunction

  assign accept_s = (state_r == IDLE) && bus.start;

  // Sweep sequencer: owns state, stimulus index, busy/done and the signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= 4'd0;
      stim_r       <= 6'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sig_r        <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            stim_r       <= 6'd0;
            settle_cnt_r <= 4'd0;
            sig_r        <= 16'hFFFF;
            busy_r       <= 1'b1;
            state_r      <= SETTLE;
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= 4'd0;
            state_r      <= SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        SAMPLE: begin
          sig_r <= misr_next(sig_r, bus.resp);
          if (stim_r != 6'd63) begin
            stim_r  <= stim_r + 6'd1;
            state_r <= SETTLE;
          end else begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.stim      = stim_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.signature = sig_r;

`ifdef QZ4_SWEEP_GOLDEN_EN
  logic [6:0] err_count_r;
  logic       ffv_r;
  logic [5:0] ffi_r;
  logic       mismatch_s;

  // Reference qz4 function evaluated bitwise on the current stimulus.
  function automatic logic [3:0] qz4_golden(input logic [5:0] s);
    logic a, b, c, d, e, f, w1, w2, w3;
    {a, b, c, d, e, f} = s;
    w1 = a ? b : c;
    w2 = w1 ? d : e;
    w3 = ~w2 ^ w1 ^ f;
    qz4_golden = {(w2 ? a : b), (w3 ? c : d), (w1 ? e : f), (w3 | (w2 & (a ^ b)))};
  endfunction

  assign mismatch_s = (bus.resp != qz4_golden(stim_r));

  // Mismatch bookkeeping: cleared on accepted start, updated in SAMPLE.
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      err_count_r <= 7'd0;
      ffv_r       <= 1'b0;
      ffi_r       <= 6'd0;
    end else if ((state_r == SAMPLE) && mismatch_s) begin
      err_count_r <= err_count_r + 7'd1;
      if (!ffv_r) begin
        ffv_r <= 1'b1;
        ffi_r <= stim_r;
      end
    end
  end

  assign bus.err_count        = err_count_r;
  assign bus.first_fail_valid = ffv_r;
  assign bus.first_fail_idx   = ffi_r;
`else
  assign bus.err_count        = 7'd0;
  assign bus.first_fail_valid = 1'b0;
  assign bus.first_fail_idx   = 6'd0;
`endif

endmodule
